fruit_controller: RTL and testbench

Sequences the bonus-fruit sprite (cherries) for one Pac-Man level: counts dots eaten, spawns the fruit at fixed dot thresholds, times its on-screen window in frames, detects Pac-Man collision, then shows a score window. It also generates the per-pixel sprite ROM address and a pipeline-aligned draw enable, so the fruit ROM/palette datapath renders only inside a 16x16 box at a fixed maze position. It sits between the game-logic pulses and the colour mux in the VGA pixel path.

---
 rtl/fruit_if.sv | 23 ++
 rtl/fruit_controller.sv | 104 ++++++++++
 tb/tb_fruit_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fruit_if.sv
// fruit_if: game-logic pulses, Pac-Man position and raster coordinates into the fruit controller, sprite controls out.
interface fruit_if;
  logic       frame_tick;
  logic       dot_eaten;
  logic       level_start;
  logic [9:0] pac_x;
  logic [9:0] pac_y;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [7:0] rom_address;
  logic       sprite_en;
  logic       fruit_active;
  logic       score_show;
  logic       fruit_eaten;
  modport master (
    output frame_tick, dot_eaten, level_start, pac_x, pac_y, DrawX, DrawY,
    input  rom_address, sprite_en, fruit_active, score_show, fruit_eaten
  );
  modport slave (
    input  frame_tick, dot_eaten, level_start, pac_x, pac_y, DrawX, DrawY,
    output rom_address, sprite_en, fruit_active, score_show, fruit_eaten
  );
endinterface

// File: rtl/fruit_controller.sv
// fruit_controller: bonus-fruit spawn/show/score sequencer plus sprite ROM addressing and aligned draw enable.
module fruit_controller #(
  parameter logic [9:0] FRUIT_X      = 10'd304,
  parameter logic [9:0] FRUIT_Y      = 10'd272,
  parameter logic [7:0] SPAWN_DOTS1  = 8'd70,
  parameter logic [7:0] SPAWN_DOTS2  = 8'd170,
  parameter logic [9:0] SHOW_FRAMES  = 10'd540,
  parameter logic [9:0] SCORE_FRAMES = 10'd120
) (
  input logic   vga_clk,
  input logic   reset_n,
  fruit_if.slave bus
);
  typedef enum logic [1:0] {WAIT, SHOW, SCORE, DONE} state_t;
  state_t      state, state_n, after;
  logic [7:0]  dot_cnt, dot_cnt_n;
  logic [1:0]  spawns, spawns_n;
  logic [9:0]  frame_cnt, frame_cnt_n;
  logic        hit, eaten_n, in_box;
  logic        active, show, eaten, en1, en2;
  logic [10:0] dx, dy, ax, ay, px, py;
  // Signed offsets from the fruit centre, folded to magnitudes for an unsigned window test
  assign dx = {1'b0, bus.pac_x} - {1'b0, FRUIT_X} - 11'd8;
  assign dy = {1'b0, bus.pac_y} - {1'b0, FRUIT_Y} - 11'd8;
  assign ax = dx[10] ? -dx : dx;
  assign ay = dy[10] ? -dy : dy;
  assign hit = ax < 11'd8 && ay < 11'd8;
  // Left/above the box wraps to a large unsigned offset, so one compare per axis suffices
  assign px = {1'b0, bus.DrawX} - {1'b0, FRUIT_X};
  assign py = {1'b0, bus.DrawY} - {1'b0, FRUIT_Y};
  assign in_box = px < 11'd16 && py < 11'd16;
  assign bus.rom_address = in_box ? {py[3:0], px[3:0]} : 8'd0;
  assign after = spawns == 2'd2 ? DONE : WAIT;
  always_comb begin
    state_n = state;
    dot_cnt_n = bus.dot_eaten && dot_cnt != 8'hFF ? dot_cnt + 8'd1 : dot_cnt;
    spawns_n = spawns;
    frame_cnt_n = frame_cnt;
    eaten_n = 1'b0;
    case (state)
      WAIT:
        if ((spawns == 2'd0 && dot_cnt >= SPAWN_DOTS1) || (spawns == 2'd1 && dot_cnt >= SPAWN_DOTS2)) begin
          state_n = SHOW;
          frame_cnt_n = '0;
          spawns_n = spawns + 2'd1;
        end
      SHOW:
        if (bus.frame_tick) begin
          if (hit) begin
            state_n = SCORE;
            frame_cnt_n = '0;
            eaten_n = 1'b1;
          end else if (frame_cnt == SHOW_FRAMES - 10'd1) begin
            state_n = after;
            frame_cnt_n = '0;
          end else
            frame_cnt_n = frame_cnt + 10'd1;
        end
      SCORE:
        if (bus.frame_tick) begin
          if (frame_cnt == SCORE_FRAMES - 10'd1) begin
            state_n = after;
            frame_cnt_n = '0;
          end else
            frame_cnt_n = frame_cnt + 10'd1;
        end
      default: ;
    endcase
    if (bus.level_start) begin
      state_n = WAIT;
      dot_cnt_n = '0;
      spawns_n = '0;
      frame_cnt_n = '0;
      eaten_n = 1'b0;
    end
  end
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state <= WAIT;
      dot_cnt <= '0;
      spawns <= '0;
      frame_cnt <= '0;
      active <= 1'b0;
      show <= 1'b0;
      eaten <= 1'b0;
      en1 <= 1'b0;
      en2 <= 1'b0;
    end else begin
      state <= state_n;
      dot_cnt <= dot_cnt_n;
      spawns <= spawns_n;
      frame_cnt <= frame_cnt_n;
      active <= state_n == SHOW;
      show <= state_n == SCORE;
      eaten <= eaten_n;
      en1 <= !bus.level_start && in_box && state == SHOW;
      en2 <= !bus.level_start && en1;
    end
  end
  assign bus.fruit_active = active;
  assign bus.score_show = show;
  assign bus.fruit_eaten = eaten;
  assign bus.sprite_en = en2;
endmodule

// File: tb/tb_fruit_controller.sv
// tb_fruit_controller: directed stimulus pushes expected output changes and snapshots; a negedge monitor pops and compares.
module tb_fruit_controller;
  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  fruit_if bus ();
  fruit_controller dut (.vga_clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int at; logic [3:0] v;} ev_t;
  typedef struct {int at; int kind; logic [7:0] v;} pr_t;
  ev_t evq[$];
  pr_t prq[$];
  ev_t e;
  pr_t p;
  logic [3:0] cur, prev;
  logic [7:0] got;
  // Output vector is {fruit_active, score_show, fruit_eaten, sprite_en}
  always @(negedge clk) begin
    cur = {bus.fruit_active, bus.score_show, bus.fruit_eaten, bus.sprite_en};
    if (mon_en) begin
      if (cur !== prev) begin
        checks++;
        if (evq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, cur, prev);
        end else begin
          e = evq.pop_front();
          if (e.at != cyc || e.v !== cur) begin
            failures++;
            $display("FAIL event cyc=%0d got=%b expected=%b at cyc=%0d", cyc, cur, e.v, e.at);
          end
        end
      end else if (evq.size() > 0 && evq[0].at < cyc) begin
        checks++;
        failures++;
        e = evq.pop_front();
        $display("FAIL missed_event cyc=%0d got=%b expected=%b at cyc=%0d", cyc, cur, e.v, e.at);
      end
      while (prq.size() > 0 && prq[0].at <= cyc) begin
        p = prq.pop_front();
        got = p.kind == 0 ? {4'b0, cur} : bus.rom_address;
        checks++;
        if (p.at != cyc || got !== p.v) begin
          failures++;
          $display("FAIL probe_%s cyc=%0d got=%0d expected=%0d at cyc=%0d", p.kind == 0 ? "outputs" : "rom_address", cyc, got, p.v, p.at);
        end
      end
    end
    prev = cur;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_ev(int at, logic [3:0] v);
    evq.push_back('{at, v});
  endtask
  task automatic probe(int at, int kind, logic [7:0] v);
    prq.push_back('{at, kind, v});
  endtask
  task automatic dots(int n);
    for (int i = 0; i < n; i++) begin
      bus.dot_eaten = 1'b1;
      step();
    end
    bus.dot_eaten = 1'b0;
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b0;
      step();
      bus.frame_tick = 1'b1;
      step();
    end
    bus.frame_tick = 1'b0;
  endtask
  task automatic pac(int x, int y);
    bus.pac_x = 10'(x);
    bus.pac_y = 10'(y);
  endtask
  task automatic pix(int x, int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
  endtask
  initial begin
    reset_n = 1'b0;
    bus.frame_tick = 1'b0;
    bus.dot_eaten = 1'b0;
    bus.level_start = 1'b0;
    pac(400, 100);
    pix(0, 0);
    repeat (3) step();
    probe(cyc, 0, 8'd0);
    mon_en = 1'b1;
    reset_n = 1'b1;
    step();
    // First spawn at exactly dot 70
    dots(69);
    probe(cyc, 0, 8'd0);
    step();
    probe(cyc, 0, 8'd0);
    dots(1);
    expect_ev(cyc + 1, 4'b1000);
    step();
    step();
    // Dots during SHOW never spawn; 170 already reached is taken on the return to WAIT
    ticks(539);
    dots(100);
    step();
    ticks(1);
    expect_ev(cyc, 4'b0000);
    expect_ev(cyc + 1, 4'b1000);
    step();
    step();
    // Raster sweep across the box on row 272
    bus.DrawY = 10'd272;
    for (int x = 300; x <= 321; x++) begin
      bus.DrawX = 10'(x);
      probe(cyc, 1, (x >= 304 && x < 320) ? 8'(x - 304) : 8'd0);
      if (x == 304) expect_ev(cyc + 2, 4'b1001);
      if (x == 320) expect_ev(cyc + 2, 4'b1000);
      step();
    end
    pix(319, 287);
    probe(cyc, 1, 8'd255);
    expect_ev(cyc + 2, 4'b1001);
    step();
    pix(310, 288);
    probe(cyc, 1, 8'd0);
    expect_ev(cyc + 2, 4'b1000);
    step();
    pix(0, 0);
    repeat (3) step();
    // Collision window edges: just outside misses, just inside hits
    pac(320, 280);
    ticks(1);
    pac(304, 280);
    ticks(1);
    pac(312, 288);
    ticks(1);
    pac(305, 273);
    ticks(1);
    expect_ev(cyc, 4'b0110);
    expect_ev(cyc + 1, 4'b0100);
    ticks(119);
    ticks(1);
    expect_ev(cyc, 4'b0000);
    // DONE ignores dots and ticks
    pac(312, 280);
    dots(70);
    ticks(3);
    step();
    // New level: eat spawn 1, score window returns to WAIT, then spawn 2
    bus.level_start = 1'b1;
    step();
    bus.level_start = 1'b0;
    dots(70);
    expect_ev(cyc + 1, 4'b1000);
    step();
    ticks(1);
    expect_ev(cyc, 4'b0110);
    expect_ev(cyc + 1, 4'b0100);
    ticks(119);
    ticks(1);
    expect_ev(cyc, 4'b0000);
    dots(100);
    expect_ev(cyc + 1, 4'b1000);
    step();
    // Hit on the expiring tick counts as eaten
    pac(400, 100);
    ticks(539);
    pac(319, 287);
    ticks(1);
    expect_ev(cyc, 4'b0110);
    expect_ev(cyc + 1, 4'b0100);
    step();
    step();
    // Reset during SCORE, then a fresh 70 dots respawn
    reset_n = 1'b0;
    step();
    expect_ev(cyc, 4'b0000);
    probe(cyc, 0, 8'd0);
    reset_n = 1'b1;
    step();
    dots(69);
    step();
    dots(1);
    expect_ev(cyc + 1, 4'b1000);
    step();
    step();
    // level_start beats a dot, a tick and a hit in the same cycle
    pac(312, 280);
    bus.level_start = 1'b1;
    bus.dot_eaten = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    expect_ev(cyc, 4'b0000);
    bus.level_start = 1'b0;
    bus.dot_eaten = 1'b0;
    bus.frame_tick = 1'b0;
    step();
    dots(69);
    step();
    step();
    dots(1);
    expect_ev(cyc + 1, 4'b1000);
    repeat (4) step();
    checks++;
    if (evq.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d expected=0", evq.size());
    end
    checks++;
    if (prq.size() != 0) begin
      failures++;
      $display("FAIL pending_probes got=%0d expected=0", prq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
